// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider: signed/unsigned quotient and remainder,
// with single-cycle early-outs for divide-by-zero and signed MIN / -1 overflow.
module alu_div #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_,
    input  logic              start,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    input  logic              cancel,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              dz,
    output logic              of
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rem, quo, dvs;
    logic              negq, negr;

    logic              a_neg, b_neg;
    logic [DATA_W-1:0] a_mag, b_mag;
    logic [DATA_W:0]   rem_sh;
    logic [DATA_W-1:0] diff;
    logic              ge;

    // Magnitudes as unsigned DATA_W values; |MIN| is exactly representable.
    always_comb begin
        a_neg  = signed_op & dividend[DATA_W-1];
        b_neg  = signed_op & divisor[DATA_W-1];
        a_mag  = a_neg ? (DATA_W'(0) - dividend) : dividend;
        b_mag  = b_neg ? (DATA_W'(0) - divisor)  : divisor;
        rem_sh = {rem, quo[DATA_W-1]};
        ge     = rem_sh >= {1'b0, dvs};
        // rem < dvs, so the true difference fits in DATA_W bits when ge is set
        diff   = rem_sh[DATA_W-1:0] - dvs;
    end

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            negq      <= 1'b0;
            negr      <= 1'b0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            dz        <= 1'b0;
            of        <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !cancel) begin
                        if (divisor == '0) begin
                            valid     <= 1'b1;
                            dz        <= 1'b1;
                            of        <= 1'b0;
                            quotient  <= '1;
                            remainder <= dividend;
                        end else if (signed_op && dividend == MIN && divisor == '1) begin
                            valid     <= 1'b1;
                            dz        <= 1'b0;
                            of        <= 1'b1;
                            quotient  <= MIN;
                            remainder <= '0;
                        end else begin
                            state <= DIV;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            rem   <= '0;
                            quo   <= a_mag;
                            dvs   <= b_mag;
                            negq  <= a_neg ^ b_neg;
                            negr  <= a_neg;
                        end
                    end
                end
                DIV: begin
                    if (cancel) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        rem <= ge ? diff : rem_sh[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], ge};
                        cnt <= cnt + 1'b1;
                        if (cnt == CW'(DATA_W - 1))
                            state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!cancel) begin
                        valid     <= 1'b1;
                        dz        <= 1'b0;
                        of        <= 1'b0;
                        quotient  <= negq ? (DATA_W'(0) - quo) : quo;
                        remainder <= negr ? (DATA_W'(0) - rem) : rem;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
